// File: rtl/case_3_mul_pipe_hs.sv
// Pipelined signed multiplier with valid/ready handshake, clock enable, tag sideband and occupancy.
// Optional macro MUL_SAT_EN: clamp overflowing products to the dout range instead of wrapping.
module case_3_mul_pipe_hs #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 15,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 15,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           ce,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [din0_WIDTH-1:0]          din0,
    input  logic [din1_WIDTH-1:0]          din1,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [dout_WIDTH-1:0]          dout,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic [$clog2(NUM_STAGE+1)-1:0] busy_cnt,
    output logic                           ovf_sticky
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int CW = $clog2(NUM_STAGE + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    generate
        if (NUM_STAGE < 1) begin : g_bad_stage
            $error("case_3_mul_pipe_hs: NUM_STAGE must be at least 1");
        end
        if (dout_WIDTH > PW) begin : g_bad_width
            $error("case_3_mul_pipe_hs: dout_WIDTH must not exceed din0_WIDTH+din1_WIDTH");
        end
    endgenerate

    // True when the full product does not fit the signed dout range.
    function automatic logic prod_ovf(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] hi;
        hi       = p >>> (dout_WIDTH - 1);
        prod_ovf = (hi != {PW{1'b0}}) && (hi != {PW{1'b1}});
    endfunction

`ifdef MUL_SAT_EN
    function automatic logic [dout_WIDTH-1:0] sat_value(input logic neg);
        sat_value = neg ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
    endfunction
`endif

    logic                  adv_s;
    logic                  acc_s;
    logic                  out_xfer_s;
    logic [PW-1:0]         a_ext_s;
    logic [PW-1:0]         b_ext_s;
    logic [PW-1:0]         prod_s;
    logic [PW-1:0]         last_prod_s;
    logic                  last_vld_s;
    logic [TAG_WIDTH-1:0]  last_tag_s;
    logic [dout_WIDTH-1:0] last_dout_s;

    logic                  out_valid_r;
    logic [dout_WIDTH-1:0] dout_r;
    logic [TAG_WIDTH-1:0]  out_tag_r;
    logic [CW-1:0]         busy_cnt_r;
    logic                  ovf_sticky_r;

    // Handshake: the whole pipe shifts when the last stage is empty or being drained.
    always_comb begin
        adv_s      = ce & (~out_valid_r | out_ready);
        acc_s      = adv_s & in_valid;
        out_xfer_s = ce & out_valid_r & out_ready;
    end

    assign a_ext_s = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
    assign b_ext_s = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
    assign prod_s  = a_ext_s * b_ext_s;

    generate
        if (NUM_STAGE == 1) begin : g_one
            assign last_prod_s = prod_s;
            assign last_vld_s  = acc_s;
            assign last_tag_s  = in_tag;
        end else begin : g_multi
            logic [NUM_STAGE-2:0] vld_r;
            logic [PW-1:0]        prod_r [NUM_STAGE-1];
            logic [TAG_WIDTH-1:0] tag_r  [NUM_STAGE-1];

            // Leading stages carry the full-width product; no bubble collapse.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    vld_r <= {(NUM_STAGE-1){1'b0}};
                    for (int i = 0; i < NUM_STAGE - 1; i++) begin
                        prod_r[i] <= {PW{1'b0}};
                        tag_r[i]  <= {TAG_WIDTH{1'b0}};
                    end
                end else if (adv_s) begin
                    vld_r[0]  <= acc_s;
                    prod_r[0] <= prod_s;
                    tag_r[0]  <= in_tag;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        vld_r[i]  <= vld_r[i-1];
                        prod_r[i] <= prod_r[i-1];
                        tag_r[i]  <= tag_r[i-1];
                    end
                end
            end

            assign last_prod_s = prod_r[NUM_STAGE-2];
            assign last_vld_s  = vld_r[NUM_STAGE-2];
            assign last_tag_s  = tag_r[NUM_STAGE-2];
        end
    endgenerate

    // Width reduction of the product entering the last stage.
    always_comb begin
`ifdef MUL_SAT_EN
        if (prod_ovf(last_prod_s)) begin
            last_dout_s = sat_value(last_prod_s[PW-1]);
        end else begin
            last_dout_s = last_prod_s[dout_WIDTH-1:0];
        end
`else
        last_dout_s = last_prod_s[dout_WIDTH-1:0];
`endif
    end

    // Last stage: data only loads with a valid product, so dout is stable across bubbles and stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_r <= 1'b0;
            dout_r      <= {dout_WIDTH{1'b0}};
            out_tag_r   <= {TAG_WIDTH{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= last_vld_s;
            if (last_vld_s) begin
                dout_r    <= last_dout_s;
                out_tag_r <= last_tag_s;
            end
        end
    end

    // Sticky overflow, raised as an overflowing product lands in the last stage.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (adv_s && last_vld_s && prod_ovf(last_prod_s)) begin
            ovf_sticky_r <= 1'b1;
        end
    end

    // Occupancy: accepts minus output transfers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            busy_cnt_r <= {CW{1'b0}};
        end else if (ce) begin
            case ({acc_s, out_xfer_s})
                2'b10:   busy_cnt_r <= busy_cnt_r + CNT_ONE;
                2'b01:   busy_cnt_r <= busy_cnt_r - CNT_ONE;
                default: busy_cnt_r <= busy_cnt_r;
            endcase
        end
    end

    assign in_ready   = adv_s;
    assign out_valid  = out_valid_r;
    assign dout       = dout_r;
    assign out_tag    = out_tag_r;
    assign busy_cnt   = busy_cnt_r;
    assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_case_3_mul_pipe_hs.sv
// Self-checking bench for case_3_mul_pipe_hs: in-order scoreboard model plus directed literal checks.
module tb_case_3_mul_pipe_hs;

    localparam int NS = 3;
    localparam int W0 = 15;
    localparam int W1 = 8;
    localparam int DW = 15;
    localparam int TW = 4;
    localparam int CW = $clog2(NS + 1);

`ifdef MUL_SAT_EN
    localparam longint T4A = 16383;
`else
    localparam longint T4A = 16257;
`endif

    logic          ap_clk    = 1'b0;
    logic          ap_rst_n  = 1'b1;
    logic          ce        = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [W0-1:0] din0      = '0;
    logic [W1-1:0] din1      = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] dout;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] busy_cnt;
    logic          ovf_sticky;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;

    case_3_mul_pipe_hs #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .dout_WIDTH(DW), .TAG_WIDTH(TW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .out_tag(out_tag),
        .busy_cnt(busy_cnt), .ovf_sticky(ovf_sticky)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint full_prod(input longint a, input longint b);
        return a * b;
    endfunction

    function automatic bit model_ovf(input longint a, input longint b);
        longint p;
        p = full_prod(a, b);
        return (p > (2**(DW-1)) - 1) || (p < -(2**(DW-1)));
    endfunction

    function automatic logic [DW-1:0] model_prod(input longint a, input longint b);
        longint p;
        p = full_prod(a, b);
`ifdef MUL_SAT_EN
        if (p > (2**(DW-1)) - 1) p = (2**(DW-1)) - 1;
        else if (p < -(2**(DW-1))) p = -(2**(DW-1));
`endif
        return p[DW-1:0];
    endfunction

    typedef struct {
        int            pos;
        logic [DW-1:0] d;
        logic [TW-1:0] tag;
        bit            ov;
    } item_t;

    item_t q[$];
    bit    m_ovf = 1'b0;

    // Model: each accepted item travels NS advancing cycles, in order, then waits for out_ready.
    always @(negedge ap_clk) begin
        bit    exp_ov;
        bit    exp_adv;
        item_t it;
        if (!ap_rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy_cnt, 0);
            chk("rst_ovf", ovf_sticky, 0);
        end else begin
            exp_ov  = (q.size() > 0) && (q[0].pos == NS);
            exp_adv = ce && (!exp_ov || out_ready);
            chk("m_out_valid", out_valid, exp_ov);
            chk("m_in_ready", in_ready, exp_adv);
            chk("m_busy", busy_cnt, q.size());
            chk("m_ovf", ovf_sticky, m_ovf);
            if (exp_ov) begin
                chk("m_dout", dout, q[0].d);
                chk("m_tag", out_tag, q[0].tag);
            end
            if (out_valid && out_ready && ce) n_out++;
            if (exp_adv) begin
                if (exp_ov) q.delete(0);
                foreach (q[i]) begin
                    q[i].pos++;
                    if (q[i].pos == NS && q[i].ov) m_ovf = 1'b1;
                end
                if (in_valid) begin
                    it.pos = 1;
                    it.d   = model_prod($signed(din0), $signed(din1));
                    it.ov  = model_ovf($signed(din0), $signed(din1));
                    it.tag = in_tag;
                    if (it.pos == NS && it.ov) m_ovf = 1'b1;
                    q.push_back(it);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic put(input int a, input int b, input int t);
        din0   = a[W0-1:0];
        din1   = b[W1-1:0];
        in_tag = t[TW-1:0];
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ce        = 1'b1;
        while (busy_cnt != 0 && k < 60) begin
            tick();
            k++;
        end
        chk("drain_busy", busy_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_dout", dout, 0);
        chk("reset_tag", out_tag, 0);
        chk("reset_busy", busy_cnt, 0);
        chk("reset_ovf", ovf_sticky, 0);
        #9 ap_rst_n = 1'b1;

        // 1: single op, latency 3
        @(posedge ap_clk); #1;
        put(100, -3, 5); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("t1_busy_one", busy_cnt, 1);
        chk("t1_early0", out_valid, 0);
        tick();
        chk("t1_early1", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_dout", longint'($signed(dout)), -300);
        chk("t1_tag", out_tag, 5);
        chk("t1_busy_still", busy_cnt, 1);
        tick();
        chk("t1_busy_zero", busy_cnt, 0);
        chk("t1_gone", out_valid, 0);

        // 2: back-to-back stream of 8
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            put(1000 - 250 * i, i - 4, (i * 3) % 16); in_valid = 1'b1;
            #1;
            chk("t2_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t2_results", n_out - base, 8);
        chk("t2_empty", out_valid, 0);

        // 3: back-pressure with 5 pushes
        base = n_out;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            put(200 + k, -(k + 1), k); in_valid = 1'b1;
            #1;
            if (in_ready) k++;
            tick();
        end
        chk("t3_accepted", k, 3);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_busy", busy_cnt, 3);
        chk("t3_valid", out_valid, 1);
        chk("t3_dout", longint'($signed(dout)), -200);
        tick(); tick();
        chk("t3_dout_held", longint'($signed(dout)), -200);
        chk("t3_tag_held", out_tag, 0);
        chk("t3_busy_held", busy_cnt, 3);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            put(200 + k, -(k + 1), k); in_valid = 1'b1;
            #1;
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        chk("t3_all_accepted", k, 5);
        drain();
        chk("t3_results", n_out - base, 5);

        // 4: overflow
        chk("t4_ovf_clear", ovf_sticky, 0);
        put(16383, 127, 1); in_valid = 1'b1;
        tick();
        put(-16384, 127, 2);
        tick(); in_valid = 1'b0;
        tick();
        chk("t4_valid_a", out_valid, 1);
        chk("t4_dout_a", longint'($signed(dout)), T4A);
        chk("t4_tag_a", out_tag, 1);
        chk("t4_ovf", ovf_sticky, 1);
        tick();
        chk("t4_dout_b", longint'($signed(dout)), -16384);
        chk("t4_tag_b", out_tag, 2);
        drain();

        // 5: clock enable freeze mid-stream
        k = 0;
        for (int c = 0; c < 16; c++) begin
            ce = !(c >= 3 && c < 7);
            if (k < 6) begin
                put(k * 37 - 50, k + 2, k + 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 3 && c < 7) begin
                chk("t5_in_ready", in_ready, 0);
                chk("t5_busy", busy_cnt, 3);
                chk("t5_valid", out_valid, 1);
                chk("t5_dout", longint'($signed(dout)), -100);
                chk("t5_tag", out_tag, 1);
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        ce = 1'b1; in_valid = 1'b0;
        chk("t5_accepted", k, 6);
        drain();

        // 6: asynchronous reset with items in flight
        chk("t6_ovf_before", ovf_sticky, 1);
        put(11, 12, 3); in_valid = 1'b1;
        tick();
        put(13, 14, 4);
        tick(); in_valid = 1'b0;
        chk("t6_busy_before", busy_cnt, 2);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_busy", busy_cnt, 0);
        chk("t6_ovf", ovf_sticky, 0);
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6_no_stale", out_valid, 0);
        end
        put(7, -8, 9); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); tick();
        chk("t6_after_valid", out_valid, 1);
        chk("t6_after_dout", longint'($signed(dout)), -56);
        chk("t6_after_tag", out_tag, 9);
        chk("t6_after_ovf", ovf_sticky, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
